// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: bit-serial add/subtract engine.
// One full-adder cell is stepped LSB-first over a WIDTH-bit operand pair,
// one bit per clock. The running carry is held in a register, and the result
// collects in a working shift register. The result is copied to the
// architectural outputs (sum/cout/overflow) only when the last bit completes,
// so those outputs keep the previous result while an operation is running.

// One-bit full adder cell: S = A^B^Cin, Cout = majority(A,B,Cin).
module serial_add_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    // Sum and carry are pure combinational functions of the three inputs.
    always_comb begin
        o_s    = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    end

endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Working registers for the operation in flight.
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;

    // Architectural result registers.
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;

    // Decoded control.
    logic w_accept;
    logic w_last;
    logic w_running;

    // Full-adder wires.
    logic w_fa_s;
    logic w_fa_cout;

    // Operand B and carry-in as loaded; subtraction is a + ~b + 1.
    logic [WIDTH-1:0] w_b_load;
    logic             w_carry_load;

    assign w_b_load     = sub ? ~b : b;
    assign w_carry_load = sub ? 1'b1 : cin;
    assign w_last       = (r_cnt == LAST_BIT);
    assign w_running    = (r_state == S_RUN);

    serial_add_fa u_fa (
        .i_a    (r_areg[0]),
        .i_b    (r_breg[0]),
        .i_cin  (r_carry),
        .o_s    (w_fa_s),
        .o_cout (w_fa_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and accept decode; clr overrides everything, including start.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (clr) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_state_next = S_RUN;
                        w_accept     = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        w_state_next = S_DONE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Bit counter: cleared on abort and accept, wraps to 0 after the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_accept) begin
            r_cnt <= '0;
        end else if (w_running) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Operand shift registers and running carry: load on accept, shift in RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_areg  <= '0;
            r_breg  <= '0;
            r_carry <= 1'b0;
        end else if (!clr) begin
            if (w_accept) begin
                r_areg  <= a;
                r_breg  <= w_b_load;
                r_carry <= w_carry_load;
            end else if (w_running) begin
                r_areg  <= {1'b0, r_areg[WIDTH-1:1]};
                r_breg  <= {1'b0, r_breg[WIDTH-1:1]};
                r_carry <= w_fa_cout;
            end
        end
    end

    // Working sum: each new bit enters at the MSB, so after WIDTH shifts
    // bit 0 of the result sits at position 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_sh <= '0;
        end else if (!clr) begin
            if (w_accept) begin
                r_sum_sh <= '0;
            end else if (w_running) begin
                r_sum_sh <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
            end
        end
    end

    // Architectural result: written only on the final bit edge. The final bit
    // is taken straight from the adder so the result is visible with done.
    // Overflow is carry into MSB (the carry register) XOR carry out of MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!clr && w_running && w_last) begin
            r_sum      <= {w_fa_s, r_sum_sh[WIDTH-1:1]};
            r_cout     <= w_fa_cout;
            r_overflow <= r_carry ^ w_fa_cout;
        end
    end

    // Handshake outputs decode registered state only.
    assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and randomised bench for serial_add_sequencer (WIDTH=8 and WIDTH=32).
module tb_serial_add_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0, clr8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, cout8, ov8;
    logic [7:0] sum8;

    serial_add_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .clr(clr8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .ready(ready8), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .overflow(ov8)
    );

    // WIDTH=32 instance
    logic        start32 = 1'b0, clr32 = 1'b0, sub32 = 1'b0, cin32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        ready32, busy32, done32, cout32, ov32;
    logic [31:0] sum32;

    serial_add_sequencer #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .clr(clr32), .sub(sub32), .cin(cin32),
        .a(a32), .b(b32), .ready(ready32), .busy(busy32), .done(done32),
        .sum(sum32), .cout(cout32), .overflow(ov32)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until done8 is seen (bounded); returns edges advanced and busy cycles seen.
    task automatic wait_done8(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (!done8 && edges < 40) begin
            if (busy8) busy_cycles++;
            step();
            edges++;
        end
        if (!done8) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done8: timeout after %0d edges", edges);
        end
    endtask

    task automatic wait_done32(output int edges);
        edges = 0;
        while (!done32 && edges < 80) begin
            step();
            edges++;
        end
    endtask

    // Count done pulses over a window of cycles.
    task automatic count_done8(input int cycles, output int dones);
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done8) dones++;
            step();
        end
    endtask

    initial begin
        int edges, bcyc, dones;
        logic [32:0] t;
        logic [31:0] bb;
        logic        cc, exp_ov;

        vecs[0] = '{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[8] = '{8'h55, 8'hAA, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};

        // Reset state
        #12;
        check("rst_ready", 32'(ready8), 32'd1);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ov", 32'(ov8), 32'd0);
        rst_n = 1'b1;
        step();
        step();

        // Table-driven operations
        for (int i = 0; i < 9; i++) begin
            check("ready_before", 32'(ready8), 32'd1);
            a8 = vecs[i].a; b8 = vecs[i].b; sub8 = vecs[i].sub; cin8 = vecs[i].cin;
            start8 = 1'b1;
            step();
            start8 = 1'b0;
            wait_done8(edges, bcyc);
            check("latency", 32'(edges + 1), 32'd9);
            check("busy_cycles", 32'(bcyc), 32'd8);
            check("sum", 32'(sum8), 32'(vecs[i].exp_sum));
            check("cout", 32'(cout8), 32'(vecs[i].exp_cout));
            check("overflow", 32'(ov8), 32'(vecs[i].exp_ov));
            $display("op%0d a=%02h b=%02h sub=%0d cin=%0d -> sum=%02h cout=%0d ov=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, sum8, cout8, ov8);
            step();
            check("done_single", 32'(done8), 32'd0);
        end

        // Start during RUN ignored; back-to-back start from DONE
        a8 = 8'h3C; b8 = 8'h05; sub8 = 1'b0; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        a8 = 8'h11; b8 = 8'h00; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8(edges, bcyc);
        check("ign_latency", 32'(edges + 4), 32'd9);
        check("ign_sum", 32'(sum8), 32'h41);
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        step();
        start8 = 1'b0;
        check("b2b_busy", 32'(busy8), 32'd1);
        check("b2b_hold_sum", 32'(sum8), 32'h41);
        wait_done8(edges, bcyc);
        check("b2b_spacing", 32'(edges + 1), 32'd9);
        check("b2b_sum", 32'(sum8), 32'h02);
        $display("b2b first=41 second sum=%02h spacing=%0d", sum8, edges + 1);
        step();

        // Asynchronous reset mid-operation
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum", 32'(sum8), 32'd0);
        check("arst_ready", 32'(ready8), 32'd1);
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_done", 32'(done8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        count_done8(20, dones);
        check("arst_no_done", 32'(dones), 32'd0);
        $display("async reset mid-op: sum=%02h dones_after=%0d", sum8, dones);

        // clr mid-operation keeps previous result
        a8 = 8'h3C; b8 = 8'h05; start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done8(edges, bcyc);
        check("pre_clr_sum", 32'(sum8), 32'h41);
        step();
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        clr8 = 1'b1;
        step();
        clr8 = 1'b0;
        check("clr_ready", 32'(ready8), 32'd1);
        check("clr_busy", 32'(busy8), 32'd0);
        check("clr_sum_kept", 32'(sum8), 32'h41);
        check("clr_cout_kept", 32'(cout8), 32'd0);
        count_done8(20, dones);
        check("clr_no_done", 32'(dones), 32'd0);
        $display("clr mid-op: sum=%02h dones=%0d", sum8, dones);

        // start and clr together: clr wins
        start8 = 1'b1; clr8 = 1'b1;
        step();
        start8 = 1'b0; clr8 = 1'b0;
        check("clr_start_busy", 32'(busy8), 32'd0);
        count_done8(12, dones);
        check("clr_start_no_done", 32'(dones), 32'd0);
        $display("start+clr: busy=%0d dones=%0d", busy8, dones);

        // WIDTH=32 random operations against a reference model
        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom_range(0, 1)); cin32 = 1'($urandom_range(0, 1));
            bb = sub32 ? ~b32 : b32;
            cc = sub32 ? 1'b1 : cin32;
            t = {1'b0, a32} + {1'b0, bb} + {32'd0, cc};
            exp_ov = (a32[31] == bb[31]) && (t[31] != a32[31]);
            start32 = 1'b1;
            step();
            start32 = 1'b0;
            wait_done32(edges);
            check("w32_latency", 32'(edges + 1), 32'd33);
            check("w32_sum", sum32, t[31:0]);
            check("w32_cout_ov", {30'd0, cout32, ov32}, {30'd0, t[32], exp_ov});
            $display("w32 op%0d a=%08h b=%08h sub=%0d cin=%0d -> sum=%08h cout=%0d ov=%0d",
                     i, a32, b32, sub32, cin32, sum32, cout32, ov32);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
